// File: rtl/temporal_epoch_ctrl_if.sv
// Host-side bus of the temporal epoch controller: epoch request and result handshake.
// The host drives the master modport and the controller implements the slave modport.
interface temporal_epoch_ctrl_if #(
  parameter int unsigned N_IN = 2,
  parameter int unsigned T_W  = 4
);
  logic                  start_valid;
  logic                  start_ready;
  logic [N_IN*T_W-1:0]   in_time;
  logic [N_IN-1:0]       in_en;
  logic                  res_valid;
  logic                  res_ready;
  logic [T_W-1:0]        res_time;
  logic                  res_none;

  modport master (
    output start_valid, in_time, in_en, res_ready,
    input  start_ready, res_valid, res_time, res_none
  );

  modport slave (
    input  start_valid, in_time, in_en, res_ready,
    output start_ready, res_valid, res_time, res_none
  );
endinterface

// File: rtl/temporal_epoch_ctrl.sv
// Sequences one race-logic epoch: clear the primitive, release timed rising edges, time y_in.
// Optional feature macro TEMPORAL_CTRL_EARLY_EXIT_EN: leave RUN right after the first capture.
module temporal_epoch_ctrl #(
  parameter int unsigned N_IN      = 2,
  parameter int unsigned T_W       = 4,
  parameter int unsigned EPOCH_MAX = 15,
  parameter int unsigned RST_CYC   = 2
) (
  input  logic                      aclk,
  input  logic                      grst,
  temporal_epoch_ctrl_if.slave      bus,
  output logic                      rst_o,
  output logic [N_IN-1:0]           edge_o,
  input  logic                      y_in,
  output logic                      busy
);

  localparam int unsigned CW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  typedef enum logic [1:0] {StIdle, StClr, StRun, StDone} state_e;

  state_e              state_q;
  logic [CW-1:0]       clr_q;
  logic [T_W-1:0]      cnt_q;
  logic                hit_q;
  logic [N_IN*T_W-1:0] time_q;
  logic [N_IN-1:0]     en_q;

  logic [T_W-1:0]      nxt_k;
  logic [N_IN-1:0]     edge_nxt;
  logic                run_exit;

  // Edges are registered, so they are computed for the step the next cycle will show.
  always_comb begin
    nxt_k = (state_q == StClr) ? '0 : cnt_q + 1'b1;
    for (int i = 0; i < int'(N_IN); i++) begin
      edge_nxt[i] = en_q[i] &
                    (time_q[i*T_W +: T_W] <= nxt_k) &
                    (time_q[i*T_W +: T_W] <= T_W'(EPOCH_MAX));
    end
`ifdef TEMPORAL_CTRL_EARLY_EXIT_EN
    run_exit = (cnt_q == T_W'(EPOCH_MAX)) | (y_in & ~hit_q);
`else
    run_exit = (cnt_q == T_W'(EPOCH_MAX));
`endif
  end

  always_ff @(posedge aclk) begin
    if (grst) begin
      state_q         <= StIdle;
      clr_q           <= '0;
      cnt_q           <= '0;
      hit_q           <= 1'b0;
      time_q          <= '0;
      en_q            <= '0;
      rst_o           <= 1'b0;
      edge_o          <= '0;
      busy            <= 1'b0;
      bus.start_ready <= 1'b1;
      bus.res_valid   <= 1'b0;
      bus.res_time    <= '0;
      bus.res_none    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start_valid) begin
            state_q         <= StClr;
            time_q          <= bus.in_time;
            en_q            <= bus.in_en;
            clr_q           <= '0;
            hit_q           <= 1'b0;
            rst_o           <= 1'b1;
            edge_o          <= '0;
            busy            <= 1'b1;
            bus.start_ready <= 1'b0;
            bus.res_time    <= '0;
            bus.res_none    <= 1'b0;
          end
        end
        StClr: begin
          if (clr_q == CW'(RST_CYC - 1)) begin
            state_q <= StRun;
            rst_o   <= 1'b0;
            cnt_q   <= '0;
            edge_o  <= edge_nxt;
          end else begin
            clr_q <= clr_q + 1'b1;
          end
        end
        StRun: begin
          if (y_in && !hit_q) begin
            hit_q        <= 1'b1;
            bus.res_time <= cnt_q;
          end
          if (run_exit) begin
            state_q       <= StDone;
            edge_o        <= '0;
            bus.res_valid <= 1'b1;
            bus.res_none  <= ~(hit_q | y_in);
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            edge_o <= edge_o | edge_nxt;
          end
        end
        StDone: begin
          if (bus.res_ready) begin
            state_q         <= StIdle;
            bus.res_valid   <= 1'b0;
            busy            <= 1'b0;
            bus.start_ready <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_temporal_epoch_ctrl.sv
// Scoreboard bench for temporal_epoch_ctrl; y_in is modelled as the AND of both edges.
module tb_temporal_epoch_ctrl;
  localparam int N_IN      = 2;
  localparam int T_W       = 4;
  localparam int EPOCH_MAX = 15;
  localparam int RST_CYC   = 2;

  logic              aclk = 1'b0;
  logic              grst = 1'b1;
  logic              rst_o;
  logic              busy;
  logic              y_in;
  logic [N_IN-1:0]   edge_o;

  always #5 aclk = ~aclk;

  temporal_epoch_ctrl_if #(.N_IN(N_IN), .T_W(T_W)) bus ();

  assign y_in = &edge_o;

  temporal_epoch_ctrl #(
    .N_IN      (N_IN),
    .T_W       (T_W),
    .EPOCH_MAX (EPOCH_MAX),
    .RST_CYC   (RST_CYC)
  ) dut (
    .aclk   (aclk),
    .grst   (grst),
    .bus    (bus),
    .rst_o  (rst_o),
    .edge_o (edge_o),
    .y_in   (y_in),
    .busy   (busy)
  );

  typedef struct {
    int t;
    int none;
    int vcyc;
  } exp_t;

  exp_t        sb[$];
  int          total  = 0;
  int          passed = 0;
  bit          seen   = 1'b0;
  int unsigned cyc    = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Monitor: check result latency when res_valid first rises, contents on handshake.
  always @(negedge aclk) begin
    if (grst) begin
      seen = 1'b0;
    end else begin
      if (bus.res_valid === 1'b1 && !seen) begin
        seen = 1'b1;
        if (sb.size() == 0) chk("unexpected_res_valid", 1, 0);
        else chk("res_valid_cycle", cyc, sb[0].vcyc);
      end
      if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1 && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("res_time", bus.res_time, e.t);
        chk("res_none", bus.res_none, e.none);
        seen = 1'b0;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge aclk);
    while (bus.start_ready !== 1'b1 && n < 40) begin
      @(negedge aclk);
      n++;
    end
    chk("start_ready_wait", bus.start_ready, 1);
  endtask

  task automatic run_epoch(input int t0, input int t1, input logic [1:0] en,
                           input int et, input int enone, input bit hold);
    int a;
    int last;
    logic [1:0] ee;
    last = EPOCH_MAX;
`ifdef TEMPORAL_CTRL_EARLY_EXIT_EN
    if (enone == 0) last = et;
`endif
    wait_ready();
    @(posedge aclk); #1;
    bus.res_ready   = !hold;
    bus.start_valid = 1'b1;
    bus.in_time     = {4'(t1), 4'(t0)};
    bus.in_en       = en;
    @(posedge aclk); #1;
    a = cyc;
    bus.start_valid = 1'b0;
    sb.push_back('{et, enone, a + last + 3});
    for (int off = 0; off <= last + 3; off++) begin
      @(negedge aclk);
      chk("rst_o", rst_o, 32'(off < RST_CYC));
      ee = '0;
      if (off >= RST_CYC && off - RST_CYC <= last) begin
        ee[0] = en[0] && (t0 <= off - RST_CYC);
        ee[1] = en[1] && (t1 <= off - RST_CYC);
      end
      chk("edge_o", edge_o, ee);
    end
    if (hold) begin
      @(posedge aclk); #1;
      bus.start_valid = 1'b1;
      bus.in_time     = '0;
      bus.in_en       = 2'b11;
      repeat (10) begin
        @(negedge aclk);
        chk("hold_res_valid", bus.res_valid, 1);
        chk("hold_res_time", bus.res_time, et);
        chk("hold_res_none", bus.res_none, enone);
        chk("hold_start_ready", bus.start_ready, 0);
      end
      @(posedge aclk); #1;
      bus.start_valid = 1'b0;
      bus.res_ready   = 1'b1;
      @(negedge aclk);
      @(posedge aclk); #1;
      @(negedge aclk);
      chk("after_done_start_ready", bus.start_ready, 1);
      chk("after_done_busy", busy, 0);
      chk("after_done_res_valid", bus.res_valid, 0);
      repeat (3) begin
        @(negedge aclk);
        chk("ignored_start_rst_o", rst_o, 0);
        chk("ignored_start_busy", busy, 0);
      end
    end
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge aclk);
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    int vcount;
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b1;
    bus.in_time     = '0;
    bus.in_en       = '0;
    @(posedge aclk); #1;
    grst = 1'b0;
    @(negedge aclk);
    chk("rst_start_ready", bus.start_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rst_o", rst_o, 0);
    chk("rst_edge_o", edge_o, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_time", bus.res_time, 0);
    chk("rst_res_none", bus.res_none, 0);

    run_epoch(3, 7, 2'b11, 7, 0, 1'b0);
    run_epoch(3, 9, 2'b01, 0, 1, 1'b0);
    run_epoch(15, 15, 2'b11, 15, 0, 1'b0);
    run_epoch(15, 0, 2'b11, 15, 0, 1'b0);
    run_epoch(15, 15, 2'b11, 15, 0, 1'b0);
    run_epoch(0, 0, 2'b11, 0, 0, 1'b0);

    // Global reset in the middle of RUN (cnt 5); no result may follow.
    wait_ready();
    @(posedge aclk); #1;
    bus.start_valid = 1'b1;
    bus.in_time     = {4'd7, 4'd3};
    bus.in_en       = 2'b11;
    @(posedge aclk); #1;
    bus.start_valid = 1'b0;
    repeat (RST_CYC + 6) @(negedge aclk);
    chk("pre_rst_edge_o", edge_o, 2'b01);
    grst = 1'b1;
    @(posedge aclk); #1;
    grst = 1'b0;
    @(negedge aclk);
    chk("midrun_rst_edge_o", edge_o, 0);
    chk("midrun_rst_start_ready", bus.start_ready, 1);
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_rst_o", rst_o, 0);
    vcount = 0;
    repeat (25) begin
      @(negedge aclk);
      if (bus.res_valid !== 1'b0) vcount++;
    end
    chk("midrun_rst_no_valid", vcount, 0);

    run_epoch(3, 7, 2'b11, 7, 0, 1'b0);
    run_epoch(3, 7, 2'b11, 7, 0, 1'b1);

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
